// File: rtl/stress_defs.sv
// Shared definitions for the stress-tracking controller family: FSM state
// encodings and the default classification thresholds.
package stress_defs;

    typedef enum logic [1:0] {
        ST_CALM     = 2'd0,
        ST_ALERT    = 2'd1,
        ST_STRESSED = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    localparam logic [7:0] DEF_HI_THR     = 8'd192;
    localparam logic [7:0] DEF_LO_THR     = 8'd64;
    localparam logic [7:0] DEF_DECAY      = 8'd4;
    localparam logic [7:0] DEF_HOLD_TICKS = 8'd16;

    localparam logic [7:0] LEVEL_MAX  = 8'd255;
    localparam logic [7:0] EVENTS_MAX = 8'd255;

endpackage

// File: rtl/stress_sat_acc.sv
// Saturating accumulate/decay datapath: computes the next stress level from
// the current level, a halved stress sum and a decay amount. The arithmetic
// runs at 10-bit signed width so that simultaneous accumulate and decay
// clamp correctly at both 0 and 255.
module stress_sat_acc
    import stress_defs::*;
(
    input  logic [7:0] level,
    input  logic [7:0] sum_in,
    input  logic       sum_valid,
    input  logic       decay_tick,
    input  logic [7:0] decay,
    output logic [7:0] level_next
);

    logic signed [9:0] acc;
    logic        [9:0] half_sum;

    // Add the halved sum and/or subtract the decay, then clamp to 0..255.
    always_comb begin
        half_sum   = {2'b00, sum_in} >> 1;
        acc        = $signed({2'b00, level});
        level_next = level;
        if (sum_valid) begin
            acc = acc + $signed(half_sum);
        end
        if (decay_tick) begin
            acc = acc - $signed({2'b00, decay});
        end
        if (acc < 10'sd0) begin
            level_next = 8'd0;
        end else if (acc > 10'sd255) begin
            level_next = LEVEL_MAX;
        end else begin
            level_next = acc[7:0];
        end
    end

endmodule

// File: rtl/stress_tracker.sv
// Stress tracker: keeps a running stress level, classifies it with a
// four-state FSM, requests rocking while stressed and counts stress entries.
//
// Handshake: rock_req is a registered copy of (state == STRESSED). It stays
// high until the rocker samples rock_ack=1 on a rising edge while the FSM is
// STRESSED; that edge moves the FSM to COOLDOWN and drops rock_req. rock_ack
// in any other state has no effect.
module stress_tracker
    import stress_defs::*;
#(
    parameter logic [7:0] HI_THR     = DEF_HI_THR,
    parameter logic [7:0] LO_THR     = DEF_LO_THR,
    parameter logic [7:0] DECAY      = DEF_DECAY,
    parameter logic [7:0] HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sum_in,
    input  logic       sum_valid,
    input  logic       decay_tick,
    input  logic       rock_ack,
    output logic [7:0] level,
    output logic [1:0] state,
    output logic       rock_req,
    output logic [7:0] events
);

    logic [7:0] level_q, level_d;
    state_e     state_q, state_d;
    logic       rock_req_q, rock_req_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] events_q, events_d;

    stress_sat_acc u_sat_acc (
        .level      (level_q),
        .sum_in     (sum_in),
        .sum_valid  (sum_valid),
        .decay_tick (decay_tick),
        .decay      (DECAY),
        .level_next (level_d)
    );

    // Next state, hold counter and event counter, all from registered level.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        events_d   = events_q;
        rock_req_d = 1'b0;
        unique case (state_q)
            ST_CALM: begin
                if (level_q >= HI_THR) begin
                    state_d = ST_STRESSED;
                end else if (level_q >= LO_THR) begin
                    state_d = ST_ALERT;
                end
            end
            ST_ALERT: begin
                if (level_q >= HI_THR) begin
                    state_d = ST_STRESSED;
                end else if (level_q < LO_THR) begin
                    state_d = ST_CALM;
                end
            end
            ST_STRESSED: begin
                if (rock_ack) begin
                    state_d = ST_COOLDOWN;
                    hold_d  = HOLD_TICKS;
                end
            end
            ST_COOLDOWN: begin
                if (hold_q == 8'd0) begin
                    if (level_q >= HI_THR) begin
                        state_d = ST_STRESSED;
                    end else if (level_q < LO_THR) begin
                        state_d = ST_CALM;
                    end else begin
                        state_d = ST_ALERT;
                    end
                end else if (decay_tick) begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = ST_CALM;
        endcase
        // Count every fresh entry into STRESSED, saturating at the top.
        if (state_d == ST_STRESSED && state_q != ST_STRESSED
            && events_q != EVENTS_MAX) begin
            events_d = events_q + 8'd1;
        end
        rock_req_d = (state_d == ST_STRESSED);
    end

    // State and datapath registers; reset abandons any request or cooldown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q    <= 8'd0;
            state_q    <= ST_CALM;
            rock_req_q <= 1'b0;
            hold_q     <= 8'd0;
            events_q   <= 8'd0;
        end else begin
            level_q    <= level_d;
            state_q    <= state_d;
            rock_req_q <= rock_req_d;
            hold_q     <= hold_d;
            events_q   <= events_d;
        end
    end

    assign level    = level_q;
    assign state    = state_q;
    assign rock_req = rock_req_q;
    assign events   = events_q;

endmodule

// File: doc/stress_tracker.md
STRESS_TRACKER -- requirements
Module: stress_tracker

Interface
REQ-001 SHALL have parameter HI_THR, default 8'd192, level at or above which the baby is classed stressed.
REQ-002 SHALL have parameter LO_THR, default 8'd64, level below which the baby is classed calm.
REQ-003 SHALL have parameter DECAY, default 8'd4, amount subtracted from level per decay_tick.
REQ-004 SHALL have parameter HOLD_TICKS, default 8'd16, number of decay_ticks spent in COOLDOWN.
REQ-005 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port sum_in  input  8  unsigned stress sum from the stress-calculator adder stage.
REQ-008 SHALL have port sum_valid  input  1  one-cycle strobe qualifying sum_in.
REQ-009 SHALL have port decay_tick  input  1  one-cycle pulse from the system timer.
REQ-010 SHALL have port rock_ack  input  1  rocker controller accepts the current request.
REQ-011 SHALL have port level  output  8  registered running stress level.
REQ-012 SHALL have port state  output  2  registered FSM state: CALM=0, ALERT=1, STRESSED=2, COOLDOWN=3.
REQ-013 SHALL have port rock_req  output  1  registered request to start rocking.
REQ-014 SHALL have port events  output  8  count of entries into STRESSED, saturating.

Function
REQ-015 On sum_valid, level SHALL become min(255, level + (sum_in >> 1)) on the next edge.
REQ-016 On decay_tick, level SHALL become max(0, level - DECAY) on the next edge.
REQ-017 When sum_valid and decay_tick coincide, level SHALL become clamp(level + (sum_in >> 1) - DECAY, 0, 255), computed at 10-bit signed width.
REQ-018 With neither strobe active, level SHALL hold.
REQ-019 The FSM SHALL evaluate the registered level, giving one cycle of latency from a level change to the state change.
REQ-020 CALM: level >= HI_THR -> STRESSED; else level >= LO_THR -> ALERT; else stay.
REQ-021 ALERT: level >= HI_THR -> STRESSED; level < LO_THR -> CALM; else stay.
REQ-022 STRESSED: rock_req SHALL be 1; the FSM SHALL stay until rock_ack=1, then -> COOLDOWN and load the hold counter with HOLD_TICKS.
REQ-023 rock_ack outside STRESSED SHALL be ignored.
REQ-024 COOLDOWN: the hold counter SHALL decrement on each decay_tick, with no wrap below 0.
REQ-025 COOLDOWN, when the hold counter = 0: level >= HI_THR -> STRESSED; level < LO_THR -> CALM; else -> ALERT.
REQ-026 rock_req SHALL equal (state == STRESSED), taken from a registered state with no combinational path from inputs.
REQ-027 events SHALL increment on every transition into STRESSED and saturate at 255.

Reset
REQ-028 While rst=1, the block SHALL asynchronously force level=0, state=CALM, rock_req=0, hold counter=0 and events=0, regardless of clk.
REQ-029 Reset mid-handshake or mid-COOLDOWN SHALL abandon the operation, with no pending request surviving reset.
REQ-030 After rst deasserts, the first update SHALL occur on the next rising clk edge.

Structure
REQ-031 A shared definitions package (stress_defs) SHALL hold the state encodings and default thresholds, for use by other controller blocks.
REQ-032 The saturating accumulate/decay datapath SHALL be a sub-module stress_sat_acc (inputs level, sum_in, sum_valid, decay_tick, DECAY; output next level).
REQ-033 FSM, hold counter and event counter SHALL live in stress_tracker.

Verification
REQ-034 Scenario 1: rst, then sum_in=200 with sum_valid for 1 cycle -> level=100 the next cycle, state=ALERT one cycle later.
REQ-035 Scenario 2: from level=200, sum_in=200 with sum_valid -> level=255 (saturated); state=STRESSED; rock_req=1; events=1.
REQ-036 Scenario 3: level=2, decay_tick -> level=0; level=100 with sum_in=20 valid plus decay_tick in the same cycle -> level=106.
REQ-037 Scenario 4: in STRESSED, hold rock_ack=0 for 5 cycles -> rock_req stays 1; pulse rock_ack -> next cycle state=COOLDOWN, rock_req=0; after 16 decay_ticks with level=50 -> CALM.
REQ-038 Scenario 5: in COOLDOWN with hold=10, assert rst asynchronously between edges -> level=0, state=CALM, rock_req=0, events=0 immediately.
REQ-039 Scenario 6: force 260 STRESSED entries -> events=255 and held there.
